// File: rtl/force_bus_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : force_bus_event_monitor
// Brief    : Turns force windows and per-lane value changes on a shared bus
//            into event records, queued in a valid/ready FIFO.
// Revision : 1.0
// ============================================================================
module force_bus_event_monitor #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   bus_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [WIDTH+2:0]   evt_data,
    output logic               forced,
    output logic [7:0]         drop_cnt
);

    localparam int LW = WIDTH / 2;
    localparam int AW = $clog2(DEPTH);
    localparam int RW = WIDTH + 3;

    localparam logic [1:0] C_KIND_CHANGE = 2'b00;
    localparam logic [1:0] C_KIND_ON     = 2'b01;
    localparam logic [1:0] C_KIND_OFF    = 2'b10;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             en_q, en_d;
    logic [1:0]       pend_q, pend_d;
    logic             fpend_q, fpend_d;
    logic [1:0]       fkind_q, fkind_d;
    logic [7:0]       drop_q, drop_d;
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [RW-1:0]    mem_q [DEPTH];
    logic [RW-1:0]    mem_d [DEPTH];

    logic [1:0]       w_chg;
    logic             w_rise, w_fall;
    logic             w_empty, w_full, w_pop, w_can_push;
    logic             w_push_f, w_push_0, w_push_1, w_push;
    logic [RW-1:0]    w_rec;

    genvar gk;
    generate
        for (gk = 0; gk < 2; gk++) begin : g_lane
            assign w_chg[gk] = (bus_in[gk*LW +: LW] != bus_q[gk*LW +: LW]);
        end
    endgenerate

    always_comb begin
        w_rise     = en & ~en_q & (state_q == ST_NORMAL);
        w_fall     = ~en & en_q & (state_q == ST_FORCED);

        w_empty    = (wr_q == rd_q);
        w_full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        w_pop      = ~w_empty & evt_ready;
        w_can_push = ~w_full | w_pop;

        w_push_f   = w_can_push & fpend_q;
        w_push_0   = w_can_push & ~fpend_q & pend_q[0];
        w_push_1   = w_can_push & ~fpend_q & ~pend_q[0] & pend_q[1];
        w_push     = w_push_f | w_push_0 | w_push_1;

        if (w_push_f)
            w_rec = {fkind_q, 1'b0, bus_q};
        else if (w_push_0)
            w_rec = {C_KIND_CHANGE, 1'b0, bus_q};
        else
            w_rec = {C_KIND_CHANGE, 1'b1, bus_q};
    end

    always_comb begin
        bus_d   = bus_in;
        en_d    = en;
        state_d = state_q;
        if (w_rise)
            state_d = ST_FORCED;
        else if (w_fall)
            state_d = ST_NORMAL;

        // Entering FORCED discards coalesced changes; a same-edge re-set wins over a push clear.
        if (w_rise) begin
            pend_d = 2'b00;
        end else begin
            pend_d[0] = ((state_q == ST_NORMAL) & w_chg[0]) | (pend_q[0] & ~w_push_0);
            pend_d[1] = ((state_q == ST_NORMAL) & w_chg[1]) | (pend_q[1] & ~w_push_1);
        end

        fpend_d = w_rise | w_fall | (fpend_q & ~w_push_f);
        fkind_d = fkind_q;
        if (w_rise)
            fkind_d = C_KIND_ON;
        else if (w_fall)
            fkind_d = C_KIND_OFF;

        drop_d = drop_q;
        if ((w_rise | w_fall) & fpend_q & ~w_push_f & (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;

        wr_d  = wr_q + (AW+1)'(w_push);
        rd_d  = rd_q + (AW+1)'(w_pop);
        mem_d = mem_q;
        if (w_push)
            mem_d[wr_q[AW-1:0]] = w_rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            bus_q   <= '0;
            en_q    <= 1'b0;
            pend_q  <= 2'b00;
            fpend_q <= 1'b0;
            fkind_q <= C_KIND_CHANGE;
            drop_q  <= 8'd0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            fpend_q <= fpend_d;
            fkind_q <= fkind_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
        end
    end

    assign evt_valid = ~w_empty;
    assign evt_data  = mem_q[rd_q[AW-1:0]];
    assign forced    = (state_q == ST_FORCED);
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_force_bus_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_force_bus_event_monitor
// Brief    : Vector table plus record scoreboard for force_bus_event_monitor.
// Revision : 1.0
// ============================================================================
module tb_force_bus_event_monitor;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  bus_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [10:0] evt_data;
    logic        forced;
    logic [7:0]  drop_cnt;

    int n_vec;
    int n_err;
    logic [10:0] sbq [$];

    typedef struct packed {
        logic        en;
        logic [7:0]  bus;
        logic        rdy;
        logic        exp_valid;
        logic [10:0] exp_data;
        logic        exp_forced;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vt [12];

    force_bus_event_monitor #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus_in    (bus_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .forced    (forced),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] rec(input logic [1:0] kind, input logic lane,
                                        input logic [7:0] snap);
        return {kind, lane, snap};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer side: every accepted record is checked against the oldest expectation.
    task automatic tick();
        if (evt_valid && evt_ready) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL record: got unexpected %0h, expected none at %0t", evt_data, $time);
            end else begin
                chk("record", 32'(evt_data), 32'(sbq.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    initial begin
        logic [7:0] bp_vals [6];
        logic [7:0] v;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        en = 1'b0;
        bus_in = 8'h00;
        evt_ready = 1'b0;

        //          en    bus    rdy   valid data                       forced drop
        vt[0]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 11'h0,                      1'b0, 8'd0};
        vt[1]  = '{1'b0, 8'h3C, 1'b1, 1'b1, rec(2'b00, 1'b0, 8'h3C),   1'b0, 8'd0};
        vt[2]  = '{1'b0, 8'h3C, 1'b1, 1'b1, rec(2'b00, 1'b1, 8'h3C),   1'b0, 8'd0};
        vt[3]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 11'h0,                      1'b0, 8'd0};
        vt[4]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 11'h0,                      1'b1, 8'd0};
        vt[5]  = '{1'b1, 8'hA5, 1'b1, 1'b1, rec(2'b01, 1'b0, 8'hA5),   1'b1, 8'd0};
        vt[6]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 11'h0,                      1'b1, 8'd0};
        vt[7]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 11'h0,                      1'b1, 8'd0};
        vt[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 11'h0,                      1'b1, 8'd0};
        vt[9]  = '{1'b0, 8'h5A, 1'b1, 1'b0, 11'h0,                      1'b0, 8'd0};
        vt[10] = '{1'b0, 8'h5A, 1'b1, 1'b1, rec(2'b10, 1'b0, 8'h5A),   1'b0, 8'd0};
        vt[11] = '{1'b0, 8'h5A, 1'b1, 1'b0, 11'h0,                      1'b0, 8'd0};

        sbq.push_back(rec(2'b00, 1'b0, 8'h3C));
        sbq.push_back(rec(2'b00, 1'b1, 8'h3C));
        sbq.push_back(rec(2'b01, 1'b0, 8'hA5));
        sbq.push_back(rec(2'b10, 1'b0, 8'h5A));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid",  32'(evt_valid), 32'd0);
        chk("reset_forced", 32'(forced),    32'd0);
        chk("reset_drop",   32'(drop_cnt),  32'd0);
        chk("reset_data",   32'(evt_data),  32'd0);

        // Reset-then-change and force window, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            en        = vt[i].en;
            bus_in    = vt[i].bus;
            evt_ready = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i),  32'(evt_valid), 32'(vt[i].exp_valid));
            chk($sformatf("vec%0d_forced", i), 32'(forced),    32'(vt[i].exp_forced));
            chk($sformatf("vec%0d_drop", i),   32'(drop_cnt),  32'(vt[i].exp_drop));
            if (vt[i].exp_valid)
                chk($sformatf("vec%0d_data", i), 32'(evt_data), 32'(vt[i].exp_data));
        end

        // Back-pressure: four records fill the FIFO, later changes coalesce into one
        bp_vals[0] = 8'h5B; bp_vals[1] = 8'h5C; bp_vals[2] = 8'h5D;
        bp_vals[3] = 8'h5E; bp_vals[4] = 8'h5F; bp_vals[5] = 8'h50;
        evt_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_in = bp_vals[k];
            if (k < 4)
                sbq.push_back(rec(2'b00, 1'b0, bp_vals[k]));
            hold(2);
        end
        sbq.push_back(rec(2'b00, 1'b0, 8'h50));
        chk("bp_valid", 32'(evt_valid), 32'd1);
        chk("bp_head",  32'(evt_data),  32'(rec(2'b00, 1'b0, 8'h5B)));
        chk("bp_drop",  32'(drop_cnt),  32'd0);
        evt_ready = 1'b1;
        hold(8);
        chk("bp_drained", 32'(evt_valid), 32'd0);
        chk("bp_sb_empty", 32'(sbq.size()), 32'd0);

        // Force drop: edges pile up while the FIFO is full
        evt_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            v = 8'h50 | 8'(k);
            bus_in = v;
            sbq.push_back(rec(2'b00, 1'b0, v));
            hold(2);
        end
        en = 1'b1; tick();
        en = 1'b0; tick();
        en = 1'b1; tick();
        sbq.push_back(rec(2'b01, 1'b0, 8'h54));
        chk("fd_forced", 32'(forced),   32'd1);
        chk("fd_drop",   32'(drop_cnt), 32'd2);
        hold(1);
        chk("fd_drop_hold", 32'(drop_cnt), 32'd2);
        evt_ready = 1'b1;
        hold(8);
        chk("fd_drained",  32'(evt_valid),  32'd0);
        chk("fd_sb_empty", 32'(sbq.size()), 32'd0);
        en = 1'b0;
        sbq.push_back(rec(2'b10, 1'b0, 8'h54));
        hold(4);
        chk("fd_off_forced", 32'(forced),    32'd0);
        chk("fd_off_valid",  32'(evt_valid), 32'd0);
        chk("fd_off_drop",   32'(drop_cnt),  32'd2);

        // Full with a pending change, then simultaneous push/pop and pointer wrap
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = 8'h50 | 8'((5 + k) % 16);
            bus_in = v;
            sbq.push_back(rec(2'b00, 1'b0, v));
            hold(2);
        end
        chk("full_head", 32'(evt_data), 32'(rec(2'b00, 1'b0, 8'h55)));
        evt_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("pushpop_valid%0d", c), 32'(evt_valid), 32'd1);
        end
        for (int k = 5; k < 17; k++) begin
            v = 8'h50 | 8'((5 + k) % 16);
            bus_in = v;
            sbq.push_back(rec(2'b00, 1'b0, v));
            hold(2);
        end
        hold(6);
        chk("wrap_drained",  32'(evt_valid),  32'd0);
        chk("wrap_sb_empty", 32'(sbq.size()), 32'd0);

        // Mid-stream asynchronous reset with three records queued
        evt_ready = 1'b0;
        for (int k = 6; k < 9; k++) begin
            bus_in = 8'h50 | 8'(k);
            hold(2);
        end
        chk("mr_queued", 32'(evt_valid), 32'd1);
        en = 1'b1;
        tick();
        chk("mr_forced_pre", 32'(forced), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid",  32'(evt_valid), 32'd0);
        chk("mr_forced", 32'(forced),    32'd0);
        chk("mr_drop",   32'(drop_cnt),  32'd0);
        chk("mr_data",   32'(evt_data),  32'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b0;
        evt_ready = 1'b1;
        sbq.push_back(rec(2'b00, 1'b0, 8'h58));
        sbq.push_back(rec(2'b00, 1'b1, 8'h58));
        hold(5);
        chk("post_valid",    32'(evt_valid),  32'd0);
        chk("post_forced",   32'(forced),     32'd0);
        chk("post_drop",     32'(drop_cnt),   32'd0);
        chk("post_sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
